mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single cache/DDR2 controller request port between two requesters: port 0 = core data port (load/store), port 1 = bulk loader (UART program/data streaming into DRAM).
- Sits between the core/IO logic and the memory controller in the top level.
- Replaces the direct data-port wiring with an arbitrated, registered request/response path plus a transaction watchdog.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT_CYCLES, 4096, cycles in S_WAIT before timeout_err is set; 0 disables the watchdog.

Ports:
- clk  in  1  single clock (cpu_clk domain).
- rst  in  1  asynchronous reset, active-high.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wd  in  DATA_W  port 0 write data.
- p0_we  in  1  port 0 write=1, read=0.
- p0_req  in  1  port 0 request level; held until p0_ready.
- p0_rd  out  DATA_W  port 0 read data; valid when p0_ready=1.
- p0_ready  out  1  port 0 one-cycle completion pulse.
- p1_addr, p1_wd, p1_we, p1_req, p1_rd, p1_ready: same as port 0, for port 1.
- mem_addr  out  ADDR_W  controller address.
- mem_wd  out  DATA_W  controller write data.
- mem_we  out  1  controller write enable.
- mem_req  out  1  controller request level.
- mem_rd  in  DATA_W  controller read data.
- mem_ready  in  1  controller completion pulse.
- mem_busy  in  1  controller cannot accept a new request.
- grant_id  out  1  port owning the current transaction.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Internal reset state: state=S_IDLE, last_grant=1, wdog=0.
- S_IDLE:
  - If (p0_req|p1_req) and !mem_busy: pick a winner, latch its addr/wd/we into mem_*, set mem_req=1 and grant_id, then go to S_WAIT.
  - Otherwise stay, with mem_req=0.
- S_WAIT:
  - mem_req and mem_* are held stable.
  - wdog increments each cycle.
  - On mem_ready: mem_req=0, latch mem_rd into the winner's pN_rd, pulse that port's pN_ready for exactly 1 cycle, update last_grant=grant_id, and go to S_DONE.
- S_DONE: 1 cycle with mem_req=0 and wdog cleared, then go to S_IDLE. This guarantees the controller sees req deassert between transactions.
- Latency:
  - pN_req seen in S_IDLE at cycle t gives mem_req=1 at t+1.
  - mem_ready at cycle r gives pN_ready=1 at r+1.
  - Minimum back-to-back spacing: 3 cycles per transaction plus controller latency.
- A requester drops its req at the cycle it sees pN_ready=1. The arbiter ignores a req that is still high during S_DONE; the requester is only re-evaluated in S_IDLE.
- Requester drops req mid-transaction: the downstream transaction still completes, pN_ready still pulses, no abort.
- mem_ready while in S_IDLE or S_DONE: ignored, no ready pulse.
- mem_busy is sampled only in S_IDLE. Busy asserting during S_WAIT has no effect.
- Watchdog (TIMEOUT_CYCLES>0): when wdog reaches TIMEOUT_CYCLES-1 in S_WAIT, set timeout_err=1 (sticky until rst). The transaction keeps waiting; no forced completion. wdog saturates and does not wrap.
- Read data for writes: pN_rd is updated with mem_rd regardless of we; the content is don't-care.
- rst asserted mid-transaction: returns immediately to the reset state, mem_req drops asynchronously, and any pending response is lost.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration. On simultaneous requests, the winner is the port != last_grant.
- ARB_RR_EN undefined: fixed priority, port 0 always wins simultaneous requests. last_grant is still maintained but unused for selection.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding: S_IDLE=2'd0, S_WAIT=2'd1, S_DONE=2'd2;
  - port id constants PORT_CORE=1'b0, PORT_LOADER=1'b1.
- One natural sub-module: arb_pick2, a combinational 2-way picker with inputs req[1:0] and last_grant, outputs gnt and valid, and the ARB_RR_EN selection inside. The FSM, datapath latches and watchdog stay in mem_port_arbiter.

Test Plan:
- Single read: p0_req=1, p0_addr=0x100, p0_we=0; model returns mem_ready with 0xDEADBEEF 5 cycles after mem_req -> mem_req=1 one cycle after p0_req, mem_addr=0x100, p0_ready pulses 1 cycle with p0_rd=0xDEADBEEF, p1_ready stays 0.
- Simultaneous: p0 and p1 both request from reset, 4 transactions total. With ARB_RR_EN, grant order is 0,1,0,1. Without it, all port-0 transactions go first (order 0,0,1,1 when p0 re-requests immediately).
- Busy hold-off: mem_busy=1 for 10 cycles while p1_req=1 -> mem_req stays 0 throughout, then rises 1 cycle after busy falls, with mem_addr=p1_addr.
- Write, then stray ready: p1 writes 0x12345678 to 0x4; after completion, inject mem_ready in S_IDLE -> mem_we=1 and mem_wd=0x12345678 during the transaction; exactly one p1_ready pulse; the stray ready produces no pulse.
- Watchdog: TIMEOUT_CYCLES=16, controller never responds -> timeout_err=1 at the 16th cycle of S_WAIT, mem_req still 1. A late mem_ready then completes normally and timeout_err stays 1.
- Reset mid-op: assert rst during S_WAIT -> mem_req, grant_id and timeout_err go to 0 immediately. After release, a new p0 request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM state codes and requester ids.
package mem_arb_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic PORT_CORE   = 1'b0;
   localparam logic PORT_LOADER = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way request picker.
// ARB_RR_EN selects round-robin on contention; otherwise port 0 has fixed priority.
module arb_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       gnt,
   output logic       valid
);

`ifdef ARB_RR_EN
   always_comb begin
      valid = |req;
      if (&req) begin
         gnt = ~last_grant;
      end else begin
         gnt = req[0] ? PORT_CORE : PORT_LOADER;
      end
   end
`else
   // last_grant is tracked by the caller but plays no role in fixed priority.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      valid = |req;
      gnt   = req[0] ? PORT_CORE : PORT_LOADER;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core data port and the bulk loader onto one memory controller port,
// with registered request/response paths and a sticky transaction watchdog. Macro: ARB_RR_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wd,
   input  logic              p0_we,
   input  logic              p0_req,
   output logic [DATA_W-1:0] p0_rd,
   output logic              p0_ready,

   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wd,
   input  logic              p1_we,
   input  logic              p1_req,
   output logic [DATA_W-1:0] p1_rd,
   output logic              p1_ready,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   output logic              mem_we,
   output logic              mem_req,
   input  logic [DATA_W-1:0] mem_rd,
   input  logic              mem_ready,
   input  logic              mem_busy,

   output logic              grant_id,
   output logic              timeout_err
);

   localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [WDOG_W-1:0] WDOG_LIMIT =
      (TIMEOUT_CYCLES == 0) ? '0 : WDOG_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_req_q, mem_req_d;
   logic [DATA_W-1:0] p0_rd_q, p0_rd_d, p1_rd_q, p1_rd_d;
   logic              p0_ready_q, p0_ready_d, p1_ready_q, p1_ready_d;
   logic              grant_q, grant_d;
   logic              timeout_q, timeout_d;

   logic              pick_gnt, pick_valid;

   arb_pick2 u_pick (
      .req        ({p1_req, p0_req}),
      .last_grant (last_grant_q),
      .gnt        (pick_gnt),
      .valid      (pick_valid)
   );

   // Saturating increment so a stuck transaction never wraps the counter.
   assign wdog_inc = (&wdog_q) ? wdog_q : wdog_q + WDOG_W'(1);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wdog_d       = wdog_q;
      mem_addr_d   = mem_addr_q;
      mem_wd_d     = mem_wd_q;
      mem_we_d     = mem_we_q;
      mem_req_d    = mem_req_q;
      p0_rd_d      = p0_rd_q;
      p1_rd_d      = p1_rd_q;
      p0_ready_d   = 1'b0;
      p1_ready_d   = 1'b0;
      grant_d      = grant_q;
      timeout_d    = timeout_q;

      unique case (state_q)
         S_IDLE: begin
            mem_req_d = 1'b0;
            wdog_d    = '0;
            if (pick_valid && !mem_busy) begin
               mem_addr_d = (pick_gnt == PORT_LOADER) ? p1_addr : p0_addr;
               mem_wd_d   = (pick_gnt == PORT_LOADER) ? p1_wd   : p0_wd;
               mem_we_d   = (pick_gnt == PORT_LOADER) ? p1_we   : p0_we;
               mem_req_d  = 1'b1;
               grant_d    = pick_gnt;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            wdog_d = wdog_inc;
            if (WDOG_EN && (wdog_inc >= WDOG_LIMIT)) begin
               timeout_d = 1'b1;
            end
            if (mem_ready) begin
               mem_req_d    = 1'b0;
               last_grant_d = grant_q;
               state_d      = S_DONE;
               if (grant_q == PORT_LOADER) begin
                  p1_rd_d    = mem_rd;
                  p1_ready_d = 1'b1;
               end else begin
                  p0_rd_d    = mem_rd;
                  p0_ready_d = 1'b1;
               end
            end
         end
         S_DONE: begin
            mem_req_d = 1'b0;
            wdog_d    = '0;
            state_d   = S_IDLE;
         end
         default: begin
            mem_req_d = 1'b0;
            wdog_d    = '0;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= PORT_LOADER;
         wdog_q       <= '0;
         mem_addr_q   <= '0;
         mem_wd_q     <= '0;
         mem_we_q     <= 1'b0;
         mem_req_q    <= 1'b0;
         p0_rd_q      <= '0;
         p1_rd_q      <= '0;
         p0_ready_q   <= 1'b0;
         p1_ready_q   <= 1'b0;
         grant_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wdog_q       <= wdog_d;
         mem_addr_q   <= mem_addr_d;
         mem_wd_q     <= mem_wd_d;
         mem_we_q     <= mem_we_d;
         mem_req_q    <= mem_req_d;
         p0_rd_q      <= p0_rd_d;
         p1_rd_q      <= p1_rd_d;
         p0_ready_q   <= p0_ready_d;
         p1_ready_q   <= p1_ready_d;
         grant_q      <= grant_d;
         timeout_q    <= timeout_d;
      end
   end

   assign mem_addr    = mem_addr_q;
   assign mem_wd      = mem_wd_q;
   assign mem_we      = mem_we_q;
   assign mem_req     = mem_req_q;
   assign p0_rd       = p0_rd_q;
   assign p1_rd       = p1_rd_q;
   assign p0_ready    = p0_ready_q;
   assign p1_ready    = p1_ready_q;
   assign grant_id    = grant_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (watchdog configured to 16 cycles).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] p0_addr = '0, p0_wd = '0, p1_addr = '0, p1_wd = '0;
   logic        p0_we = 1'b0, p0_req = 1'b0, p1_we = 1'b0, p1_req = 1'b0;
   logic [31:0] p0_rd, p1_rd, mem_addr, mem_wd;
   logic        p0_ready, p1_ready, mem_we, mem_req, grant_id, timeout_err;
   logic [31:0] mem_rd = '0;
   logic        mem_ready = 1'b0, mem_busy = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .p0_addr     (p0_addr),
      .p0_wd       (p0_wd),
      .p0_we       (p0_we),
      .p0_req      (p0_req),
      .p0_rd       (p0_rd),
      .p0_ready    (p0_ready),
      .p1_addr     (p1_addr),
      .p1_wd       (p1_wd),
      .p1_we       (p1_we),
      .p1_req      (p1_req),
      .p1_rd       (p1_rd),
      .p1_ready    (p1_ready),
      .mem_addr    (mem_addr),
      .mem_wd      (mem_wd),
      .mem_we      (mem_we),
      .mem_req     (mem_req),
      .mem_rd      (mem_rd),
      .mem_ready   (mem_ready),
      .mem_busy    (mem_busy),
      .grant_id    (grant_id),
      .timeout_err (timeout_err)
   );

   // Inputs change and outputs are sampled 1ns after the active edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst = 1'b1;
      p0_req = 1'b0; p1_req = 1'b0; p0_we = 1'b0; p1_we = 1'b0;
      mem_ready = 1'b0; mem_busy = 1'b0;
      tick;
      tick;
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      n_checks++;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      n_checks++;
      if (mem_addr !== 32'h0 || mem_wd !== 32'h0 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mem_bus: got addr=%h wd=%h we=%b want all 0", mem_addr, mem_wd, mem_we);
      end
      n_checks++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b0 || p0_rd !== 32'h0 || p1_rd !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_ports: got rdy=%b%b rd0=%h rd1=%h want all 0",
                  p0_ready, p1_ready, p0_rd, p1_rd);
      end
      n_checks++;
      if (grant_id !== 1'b0 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got grant=%b tmo=%b want 0 0", grant_id, timeout_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_single_read;
      p0_addr = 32'h100; p0_we = 1'b0; p0_req = 1'b1;
      tick;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || grant_id !== 1'b0) begin
         n_fail++;
         $display("FAIL read_issue: got req=%b addr=%h we=%b gnt=%b want 1 00000100 0 0",
                  mem_req, mem_addr, mem_we, grant_id);
      end
      for (int i = 0; i < 4; i++) begin
         tick;
         n_checks++;
         if (mem_req !== 1'b1 || p0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL read_wait%0d: got req=%b p0_ready=%b want 1 0", i, mem_req, p0_ready);
         end
      end
      mem_ready = 1'b1; mem_rd = 32'hDEADBEEF;
      tick;
      mem_ready = 1'b0;
      n_checks++;
      if (p0_ready !== 1'b1 || p0_rd !== 32'hDEADBEEF || p1_ready !== 1'b0 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL read_done: got p0_ready=%b p0_rd=%h p1_ready=%b req=%b want 1 deadbeef 0 0",
                  p0_ready, p0_rd, p1_ready, mem_req);
      end
      p0_req = 1'b0;
      tick;
      n_checks++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL read_pulse_width: got p0_ready=%b p1_ready=%b want 0 0", p0_ready, p1_ready);
      end
      tick;
   endtask

   task automatic test_simultaneous;
      logic exp_order [4];
      int   rem0, rem1;
      bit   ok;
      logic g;
`ifdef ARB_RR_EN
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_order = '{1'b0, 1'b0, 1'b1, 1'b1};
`endif
      apply_reset;
      p0_addr = 32'h10; p1_addr = 32'h20; p0_we = 1'b0; p1_we = 1'b0;
      rem0 = 2; rem1 = 2;
      p0_req = 1'b1; p1_req = 1'b1;
      for (int t = 0; t < 4; t++) begin
         ok = 1'b0;
         for (int c = 0; c < 20; c++) begin
            tick;
            if (mem_req === 1'b1) begin ok = 1'b1; break; end
         end
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL simul_req%0d: got no mem_req within 20 cycles want mem_req=1", t);
            break;
         end
         g = grant_id;
         n_checks++;
         if (grant_id !== exp_order[t] || mem_addr !== (exp_order[t] ? 32'h20 : 32'h10)) begin
            n_fail++;
            $display("FAIL simul_grant%0d: got gnt=%b addr=%h want gnt=%b", t, grant_id, mem_addr,
                     exp_order[t]);
         end
         tick;
         mem_ready = 1'b1; mem_rd = 32'hA000_0000 + 32'(t);
         tick;
         mem_ready = 1'b0;
         n_checks++;
         if (exp_order[t]) begin
            if (p1_ready !== 1'b1 || p1_rd !== 32'hA000_0000 + 32'(t) || p0_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL simul_resp%0d: got p1_ready=%b p1_rd=%h p0_ready=%b want 1 %h 0",
                        t, p1_ready, p1_rd, p0_ready, 32'hA000_0000 + 32'(t));
            end
         end else begin
            if (p0_ready !== 1'b1 || p0_rd !== 32'hA000_0000 + 32'(t) || p1_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL simul_resp%0d: got p0_ready=%b p0_rd=%h p1_ready=%b want 1 %h 0",
                        t, p0_ready, p0_rd, p1_ready, 32'hA000_0000 + 32'(t));
            end
         end
         if (g == 1'b0) begin
            rem0--;
            if (rem0 <= 0) p0_req = 1'b0;
         end else begin
            rem1--;
            if (rem1 <= 0) p1_req = 1'b0;
         end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      tick;
      tick;
   endtask

   task automatic test_busy;
      int early;
      early = 0;
      mem_busy = 1'b1;
      p1_addr = 32'h40; p1_we = 1'b0; p1_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (mem_req !== 1'b0) early++;
      end
      n_checks++;
      if (early != 0) begin
         n_fail++;
         $display("FAIL busy_holdoff: got mem_req high in %0d cycles want 0", early);
      end
      mem_busy = 1'b0;
      tick;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h40 || grant_id !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_release: got req=%b addr=%h gnt=%b want 1 00000040 1",
                  mem_req, mem_addr, grant_id);
      end
      mem_ready = 1'b1; mem_rd = 32'h0000_0040;
      tick;
      mem_ready = 1'b0; p1_req = 1'b0;
      n_checks++;
      if (p1_ready !== 1'b1 || p1_rd !== 32'h0000_0040) begin
         n_fail++;
         $display("FAIL busy_resp: got p1_ready=%b p1_rd=%h want 1 00000040", p1_ready, p1_rd);
      end
      tick;
      tick;
   endtask

   task automatic test_write_stray;
      int pulses, stray;
      pulses = 0; stray = 0;
      p1_addr = 32'h4; p1_wd = 32'h12345678; p1_we = 1'b1; p1_req = 1'b1;
      tick;
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wd !== 32'h12345678 || mem_addr !== 32'h4) begin
         n_fail++;
         $display("FAIL write_issue: got req=%b we=%b wd=%h addr=%h want 1 1 12345678 00000004",
                  mem_req, mem_we, mem_wd, mem_addr);
      end
      // busy during the transaction must not disturb it
      mem_busy = 1'b1;
      tick;
      mem_busy = 1'b0;
      n_checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wd !== 32'h12345678) begin
         n_fail++;
         $display("FAIL write_hold: got req=%b we=%b wd=%h want 1 1 12345678", mem_req, mem_we, mem_wd);
      end
      mem_ready = 1'b1; mem_rd = 32'h5555_5555;
      tick;
      mem_ready = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
      if (p1_ready === 1'b1) pulses++;
      tick;
      if (p1_ready === 1'b1) pulses++;
      tick;
      if (p1_ready === 1'b1) pulses++;
      mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (p0_ready === 1'b1 || p1_ready === 1'b1) stray++;
         tick;
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL write_pulses: got %0d p1_ready pulses want 1", pulses);
      end
      n_checks++;
      if (stray != 0 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_ready: got %0d pulses mem_req=%b want 0 0", stray, mem_req);
      end
   endtask

   task automatic test_watchdog;
      int early;
      early = 0;
      p0_addr = 32'h200; p0_we = 1'b0; p0_req = 1'b1;
      tick;
      // now in cycle 1 of S_WAIT
      for (int c = 1; c <= 15; c++) begin
         if (timeout_err !== 1'b0) early++;
         if (c < 15) tick;
      end
      n_checks++;
      if (early != 0) begin
         n_fail++;
         $display("FAIL wdog_early: got timeout_err high in %0d of cycles 1..15 want 0", early);
      end
      tick;
      n_checks++;
      if (timeout_err !== 1'b1 || mem_req !== 1'b1) begin
         n_fail++;
         $display("FAIL wdog_fire: got tmo=%b req=%b at wait cycle 16 want 1 1", timeout_err, mem_req);
      end
      tick;
      tick;
      mem_ready = 1'b1; mem_rd = 32'h0BAD_0BAD;
      tick;
      mem_ready = 1'b0; p0_req = 1'b0;
      n_checks++;
      if (p0_ready !== 1'b1 || p0_rd !== 32'h0BAD_0BAD || timeout_err !== 1'b1) begin
         n_fail++;
         $display("FAIL wdog_late_resp: got p0_ready=%b p0_rd=%h tmo=%b want 1 0bad0bad 1",
                  p0_ready, p0_rd, timeout_err);
      end
      tick;
      tick;
      n_checks++;
      if (timeout_err !== 1'b1) begin
         n_fail++;
         $display("FAIL wdog_sticky: got tmo=%b want 1", timeout_err);
      end
   endtask

   task automatic test_reset_mid_op;
      p1_addr = 32'h80; p1_we = 1'b0; p1_req = 1'b1;
      tick;
      n_checks++;
      if (mem_req !== 1'b1 || grant_id !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre: got req=%b gnt=%b want 1 1", mem_req, grant_id);
      end
      tick;
      rst = 1'b1;
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || grant_id !== 1'b0 || timeout_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async: got req=%b gnt=%b tmo=%b want 0 0 0", mem_req, grant_id, timeout_err);
      end
      p1_req = 1'b0;
      tick;
      rst = 1'b0;
      p0_addr = 32'h300; p0_we = 1'b0; p0_req = 1'b1;
      tick;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 || grant_id !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_recover_issue: got req=%b addr=%h gnt=%b want 1 00000300 0",
                  mem_req, mem_addr, grant_id);
      end
      tick;
      mem_ready = 1'b1; mem_rd = 32'hCAFEF00D;
      tick;
      mem_ready = 1'b0; p0_req = 1'b0;
      n_checks++;
      if (p0_ready !== 1'b1 || p0_rd !== 32'hCAFEF00D || p1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_recover_resp: got p0_ready=%b p0_rd=%h p1_ready=%b want 1 cafef00d 0",
                  p0_ready, p0_rd, p1_ready);
      end
      tick;
      tick;
   endtask

   initial begin
      test_reset;
      test_single_read;
      test_simultaneous;
      test_busy;
      test_write_stray;
      test_watchdog;
      test_reset_mid_op;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got simulation still running want finished");
      $fatal(1);
   end

endmodule
